// File: rtl/pixel_adc_ctrl_if.sv
// Control and readout bus of the 2x2 pixel ADC sequencer.
// The sequencer takes the master view; the frame requester / pixel front end takes the slave view.
interface pixel_adc_ctrl_if;
  logic       start;
  logic [7:0] expose_time;
  logic [3:0] cmp;
  logic       erase;
  logic       expose;
  logic [7:0] ramp_code;
  logic [7:0] row1;
  logic [7:0] row2;
  logic       sel;
  logic       write_enable;
  logic       busy;
  logic       done;

  modport master (
    input  start, expose_time, cmp,
    output erase, expose, ramp_code, row1, row2, sel, write_enable, busy, done
  );

  modport slave (
    output start, expose_time, cmp,
    input  erase, expose, ramp_code, row1, row2, sel, write_enable, busy, done
  );
endinterface

// File: rtl/pixel_adc_ctrl.sv
// Single-slope conversion and readout sequencer for a 2x2 pixel array.
// Each frame runs erase, expose, an 8-bit ramp conversion and a two-beat buffer write.
module pixel_adc_ctrl #(
  parameter int ERASE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  pixel_adc_ctrl_if.master    bus
);

  localparam logic [7:0] ERASE_LEN = 8'(ERASE_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_READ0,
    S_READ1,
    S_DONE
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic [7:0] exp_len;
  logic [7:0] code [4];
  logic [3:0] captured;

  logic       erase_r;
  logic       expose_r;
  logic [7:0] ramp_r;
  logic [7:0] row1_r;
  logic [7:0] row2_r;
  logic       sel_r;
  logic       we_r;
  logic       busy_r;
  logic       done_r;

  logic [7:0] cap_code [4];
  logic [7:0] sat_code [4];
  logic [3:0] cap_flag;

  // First-crossing capture against the registered ramp value; sat_code is what
  // each pixel ends with if this is the last ramp step.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cap_flag[i] = captured[i] | bus.cmp[i];
      cap_code[i] = (bus.cmp[i] && !captured[i]) ? ramp_r : code[i];
      sat_code[i] = cap_flag[i] ? cap_code[i] : 8'hFF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      exp_len  <= '0;
      captured <= '0;
      for (int i = 0; i < 4; i++) code[i] <= '0;
      erase_r  <= 1'b0;
      expose_r <= 1'b0;
      ramp_r   <= '0;
      row1_r   <= '0;
      row2_r   <= '0;
      sel_r    <= 1'b0;
      we_r     <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state    <= S_ERASE;
            exp_len  <= (bus.expose_time == 8'd0) ? 8'd1 : bus.expose_time;
            captured <= '0;
            for (int i = 0; i < 4; i++) code[i] <= '0;
            cnt      <= 8'd1;
            erase_r  <= 1'b1;
            busy_r   <= 1'b1;
          end
        end

        S_ERASE: begin
          if (cnt == ERASE_LEN) begin
            state    <= S_EXPOSE;
            cnt      <= 8'd1;
            erase_r  <= 1'b0;
            expose_r <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        S_EXPOSE: begin
          if (cnt == exp_len) begin
            state    <= S_CONVERT;
            cnt      <= '0;
            expose_r <= 1'b0;
            ramp_r   <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        // On the last step the saturated codes go straight onto the first beat.
        S_CONVERT: begin
          if (ramp_r == 8'hFF) begin
            state    <= S_READ0;
            captured <= 4'hF;
            for (int i = 0; i < 4; i++) code[i] <= sat_code[i];
            ramp_r   <= 8'd0;
            we_r     <= 1'b1;
            sel_r    <= 1'b0;
            row1_r   <= sat_code[0];
            row2_r   <= sat_code[1];
          end else begin
            captured <= cap_flag;
            for (int i = 0; i < 4; i++) code[i] <= cap_code[i];
            ramp_r   <= ramp_r + 8'd1;
          end
        end

        S_READ0: begin
          state  <= S_READ1;
          sel_r  <= 1'b1;
          row1_r <= code[2];
          row2_r <= code[3];
        end

        S_READ1: begin
          state  <= S_DONE;
          we_r   <= 1'b0;
          sel_r  <= 1'b0;
          row1_r <= '0;
          row2_r <= '0;
          done_r <= 1'b1;
        end

        S_DONE: begin
          state  <= S_IDLE;
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end

        default: begin
          state    <= S_IDLE;
          erase_r  <= 1'b0;
          expose_r <= 1'b0;
          ramp_r   <= '0;
          row1_r   <= '0;
          row2_r   <= '0;
          sel_r    <= 1'b0;
          we_r     <= 1'b0;
          busy_r   <= 1'b0;
          done_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.erase        = erase_r;
  assign bus.expose       = expose_r;
  assign bus.ramp_code    = ramp_r;
  assign bus.row1         = row1_r;
  assign bus.row2         = row2_r;
  assign bus.sel          = sel_r;
  assign bus.write_enable = we_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;

endmodule

// File: tb/tb_pixel_adc_ctrl.sv
// Scoreboard bench for pixel_adc_ctrl: stimulus queues expected write beats,
// a monitor pops and compares them whenever write_enable is seen.
module tb_pixel_adc_ctrl;

  localparam int ERASE = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pixel_adc_ctrl_if bus();

  pixel_adc_ctrl #(.ERASE_CYCLES(ERASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       sel;
    logic [7:0] r1;
    logic [7:0] r2;
  } beat_t;

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    beat_count = 0;
  int    done_count = 0;
  beat_t exp_q[$];
  int    done_cycles[$];
  beat_t mon_beat;

  logic [8:0] thr [4];
  logic [3:0] pulse;
  logic [3:0] cmp_model;

  // Pixel model: a level comparator that trips at thr, or a single-step pulse at thr.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (pulse[i]) cmp_model[i] = ({1'b0, bus.ramp_code} == thr[i]);
      else          cmp_model[i] = ({1'b0, bus.ramp_code} >= thr[i]);
    end
  end
  assign bus.cmp = cmp_model;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  function automatic logic [7:0] expCode(input logic [8:0] t);
    return (t > 9'd255) ? 8'hFF : t[7:0];
  endfunction

  function automatic int allOutputs();
    return int'({bus.erase, bus.expose, bus.ramp_code, bus.row1, bus.row2,
                 bus.sel, bus.write_enable, bus.busy, bus.done});
  endfunction

  always @(negedge clk) begin
    if (!reset && bus.write_enable) begin
      beat_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_beat: got sel=%0d row1=0x%0h row2=0x%0h expected no beat",
                 bus.sel, bus.row1, bus.row2);
      end else begin
        mon_beat = exp_q.pop_front();
        checkOutput("beat_sel",  int'(bus.sel),  int'(mon_beat.sel));
        checkOutput("beat_row1", int'(bus.row1), int'(mon_beat.r1));
        checkOutput("beat_row2", int'(bus.row2), int'(mon_beat.r2));
      end
    end
    if (!reset && bus.done) begin
      done_count++;
      done_cycles.push_back(cyc);
    end
  end

  // Programs the pixel model, queues the expected beats and raises start before edge 0.
  task automatic applyStimulus(input logic [7:0] exp_t, input logic [8:0] t0, input logic [8:0] t1,
                               input logic [8:0] t2, input logic [8:0] t3,
                               input logic [3:0] pmask, input int frames);
    thr[0] = t0; thr[1] = t1; thr[2] = t2; thr[3] = t3;
    pulse = pmask;
    for (int f = 0; f < frames; f++) begin
      exp_q.push_back('{sel: 1'b0, r1: expCode(t0), r2: expCode(t1)});
      exp_q.push_back('{sel: 1'b1, r1: expCode(t2), r2: expCode(t3)});
    end
    @(negedge clk);
    bus.expose_time = exp_t;
    bus.start = 1'b1;
  endtask

  // Walks cycles 1.. of a frame whose start was sampled at edge 0 and checks phase timing.
  task automatic observeFrame(input int e_len, input bit poke);
    int total, erase_first, erase_last, exp_first, exp_last, we_first, we_n, done_at, busy_after, ramp_mid;
    total = ERASE + e_len + 259;
    erase_first = -1; erase_last = -1; exp_first = -1; exp_last = -1;
    we_first = -1; we_n = 0; done_at = -1; busy_after = -1; ramp_mid = -1;
    for (int n = 1; n <= total + 2; n++) begin
      @(negedge clk);
      bus.start = poke && (n == 10 || n == 100 || n == total - 1 || n == total);
      if (bus.erase)  begin if (erase_first < 0) erase_first = n; erase_last = n; end
      if (bus.expose) begin if (exp_first < 0) exp_first = n; exp_last = n; end
      if (bus.write_enable) begin if (we_first < 0) we_first = n; we_n++; end
      if (bus.done && done_at < 0) done_at = n;
      if (n == total + 1) busy_after = int'(bus.busy);
      if (n == 1 + ERASE + e_len + 128) ramp_mid = int'(bus.ramp_code);
    end
    checkOutput("erase_first",  erase_first, 1);
    checkOutput("erase_last",   erase_last,  ERASE);
    checkOutput("expose_first", exp_first,   ERASE + 1);
    checkOutput("expose_last",  exp_last,    ERASE + e_len);
    checkOutput("ramp_mid",     ramp_mid,    128);
    checkOutput("read0_cycle",  we_first,    257 + ERASE + e_len);
    checkOutput("beats_per_frame", we_n,     2);
    checkOutput("done_cycle",   done_at,     259 + ERASE + e_len);
    checkOutput("busy_after",   busy_after,  0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: got no finish expected finish before timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int found, d0, b0, seen, sz;
    bus.start = 1'b0;
    bus.expose_time = 8'd0;
    for (int i = 0; i < 4; i++) thr[i] = 9'd256;
    pulse = 4'b0;

    $display("[TB] reset and idle");
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", allOutputs(), 0);
    reset = 1'b0;
    found = 0;
    repeat (20) begin
      @(negedge clk);
      if (allOutputs() != 0) found = 1;
    end
    checkOutput("idle_outputs", found, 0);
    checkOutput("idle_busy", int'(bus.busy), 0);

    $display("[TB] nominal frame");
    applyStimulus(8'd10, 9'h10, 9'h80, 9'hFF, 9'h00, 4'b0000, 1);
    observeFrame(10, 1'b0);

    $display("[TB] saturation and glitch");
    applyStimulus(8'd10, 9'h40, 9'd256, 9'h33, 9'd256, 4'b0001, 1);
    observeFrame(10, 1'b0);

    $display("[TB] zero exposure with start pokes while busy");
    applyStimulus(8'd0, 9'h05, 9'h06, 9'h07, 9'h08, 4'b0000, 1);
    observeFrame(1, 1'b1);
    b0 = beat_count;
    repeat (20) @(negedge clk);
    checkOutput("no_extra_beats", beat_count - b0, 0);
    checkOutput("idle_after_pokes", int'(bus.busy), 0);

    $display("[TB] reset during conversion");
    b0 = beat_count;
    applyStimulus(8'd10, 9'h20, 9'h30, 9'h40, 9'h50, 4'b0000, 0);
    found = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.ramp_code == 8'h55) begin
        found = 1;
        break;
      end
    end
    checkOutput("reach_ramp55", found, 1);
    reset = 1'b1;
    #1;
    checkOutput("reset_midframe_outputs", allOutputs(), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("after_reset_outputs", allOutputs(), 0);
    checkOutput("partial_frame_beats", beat_count - b0, 0);

    applyStimulus(8'd10, 9'h60, 9'h70, 9'h01, 9'h02, 4'b0000, 1);
    observeFrame(10, 1'b0);

    $display("[TB] back-to-back frames");
    d0 = done_count;
    b0 = beat_count;
    applyStimulus(8'd10, 9'h11, 9'h22, 9'h33, 9'h44, 4'b0000, 3);
    seen = 0;
    for (int k = 0; k < 1200; k++) begin
      @(negedge clk);
      if (bus.done) begin
        seen++;
        if (seen == 3) begin
          bus.start = 1'b0;
          break;
        end
      end
    end
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("b2b_done_pulses", done_count - d0, 3);
    checkOutput("b2b_beats", beat_count - b0, 6);
    sz = done_cycles.size();
    if (sz >= 3 && done_count - d0 == 3) begin
      checkOutput("b2b_period_1", done_cycles[sz-2] - done_cycles[sz-3], ERASE + 10 + 260);
      checkOutput("b2b_period_2", done_cycles[sz-1] - done_cycles[sz-2], ERASE + 10 + 260);
    end else begin
      checkOutput("b2b_done_history", done_count - d0, 3);
    end

    checkOutput("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
